// File: rtl/irq_timer_unit.sv
`default_nettype none
// ============================================================================
// Module   : irq_timer_unit
// Purpose  : Interrupt source for the fetch stage. Two edge-detected external
//            IO request lines plus two programmable down-counters (one-shot or
//            auto-reload) drive a 4-bit one-cycle interrupt pulse vector.
//            Software access through a word-addressed register port.
// Ports    : clk        - core clock
//            reset      - synchronous, active-high reset
//            io_irq     - asynchronous external requests, rising-edge triggered
//            we / re    - register write / read strobes
//            addr       - register word address
//            wdata      - write data
//            rdata      - registered read data (1-cycle latency)
//            interrupts - {counter1, counter0, io1, io0} one-cycle pulses
// Register map:
//            0 CTRL   {ioen1,ioen0,reload1,reload0,en1,en0}
//            1 LOAD0  2 LOAD1  3 COUNT0 (RO)  4 COUNT1 (RO)
//            5 STATUS sticky copies of interrupts, write-1-to-clear
// Revision : 1.0 - initial release
// ============================================================================
module irq_timer_unit #(
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  io_irq,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  interrupts
);

    localparam int         PRE_W         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [2:0] C_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] C_ADDR_LOAD0  = 3'd1;
    localparam logic [2:0] C_ADDR_LOAD1  = 3'd2;
    localparam logic [2:0] C_ADDR_COUNT0 = 3'd3;
    localparam logic [2:0] C_ADDR_COUNT1 = 3'd4;
    localparam logic [2:0] C_ADDR_STATUS = 3'd5;

    // Channel phase is fully determined by the enable bit and the count, so it
    // is decoded from those registers rather than held in a separate flop that
    // could drift out of step with software writes.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cnt_state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       r_en;
    logic [1:0]       r_reload;
    logic [1:0]       r_ioen;
    logic [CNT_W-1:0] r_load  [2];
    logic [CNT_W-1:0] r_count [2];
    logic [3:0]       r_status;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_hist;

    // ------------------------------------------------------------------
    // Combinational next-state
    // ------------------------------------------------------------------
    logic             w_tick;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic [1:0]       w_wr_load;
    cnt_state_t       w_state     [2];
    logic [CNT_W-1:0] w_count_nxt [2];
    logic [1:0]       w_en_hw;
    logic [1:0]       w_cnt_fire;
    logic [1:0]       w_io_fire;
    logic [3:0]       w_irq_nxt;
    logic [3:0]       w_status_nxt;
    logic [5:0]       w_ctrl_nxt;
    logic [31:0]      w_rd_val;

    assign w_wr_ctrl    = we && (addr == C_ADDR_CTRL);
    assign w_wr_status  = we && (addr == C_ADDR_STATUS);
    assign w_wr_load[0] = we && (addr == C_ADDR_LOAD0);
    assign w_wr_load[1] = we && (addr == C_ADDR_LOAD1);

    // ------------------------------------------------------------------
    // Prescaler: free-running 0..PRESCALE-1, tick on the terminal value
    // ------------------------------------------------------------------
    generate
        if (PRESCALE <= 1) begin : g_pre_bypass
            assign w_tick = 1'b1;
        end else begin : g_pre_cnt
            localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(PRESCALE - 1);
            logic [PRE_W-1:0] r_pre;

            assign w_tick = (r_pre == C_PRE_MAX);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pre <= '0;
                end else if (w_tick) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counter channels: decrement on tick, fire on the 1 -> expire edge.
    // A LOAD write takes priority over the tick and suppresses the pulse.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_state[k]     = (r_en[k] && (r_count[k] != '0)) ? ST_RUN : ST_IDLE;
            w_count_nxt[k] = r_count[k];
            w_en_hw[k]     = r_en[k];
            w_cnt_fire[k]  = 1'b0;
            if (w_wr_load[k]) begin
                w_count_nxt[k] = wdata[CNT_W-1:0];
            end else if ((w_state[k] == ST_RUN) && w_tick) begin
                if (r_count[k] == CNT_W'(1)) begin
                    w_cnt_fire[k] = 1'b1;
                    if (r_reload[k]) begin
                        w_count_nxt[k] = r_load[k];
                    end else begin
                        w_count_nxt[k] = '0;
                        w_en_hw[k]     = 1'b0;
                    end
                end else begin
                    w_count_nxt[k] = r_count[k] - CNT_W'(1);
                end
            end
        end
    end

    // A software CTRL write overrides the hardware one-shot enable clear.
    assign w_ctrl_nxt = w_wr_ctrl ? wdata[5:0] : {r_ioen, r_reload, w_en_hw};

    // IO edge detect after the 2-flop synchroniser.
    assign w_io_fire = r_sync2 & ~r_hist & r_ioen;

    assign w_irq_nxt = {w_cnt_fire, w_io_fire};

    // Set wins over a same-edge write-1-to-clear.
    assign w_status_nxt = (r_status & ~(w_wr_status ? wdata[3:0] : 4'b0000)) | w_irq_nxt;

    // ------------------------------------------------------------------
    // Read mux (pre-write values; zero-extended)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_val = '0;
        case (addr)
            C_ADDR_CTRL:   w_rd_val[5:0]       = {r_ioen, r_reload, r_en};
            C_ADDR_LOAD0:  w_rd_val[CNT_W-1:0] = r_load[0];
            C_ADDR_LOAD1:  w_rd_val[CNT_W-1:0] = r_load[1];
            C_ADDR_COUNT0: w_rd_val[CNT_W-1:0] = r_count[0];
            C_ADDR_COUNT1: w_rd_val[CNT_W-1:0] = r_count[1];
            C_ADDR_STATUS: w_rd_val[3:0]       = r_status;
            default:       w_rd_val            = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en       <= '0;
            r_reload   <= '0;
            r_ioen     <= '0;
            r_status   <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_hist     <= '0;
            rdata      <= '0;
            interrupts <= '0;
            for (int k = 0; k < 2; k++) begin
                r_load[k]  <= '0;
                r_count[k] <= '0;
            end
        end else begin
            {r_ioen, r_reload, r_en} <= w_ctrl_nxt;
            r_status   <= w_status_nxt;
            r_sync1    <= io_irq;
            r_sync2    <= r_sync1;
            r_hist     <= r_sync2;
            interrupts <= w_irq_nxt;
            if (re) begin
                rdata <= w_rd_val;
            end
            for (int k = 0; k < 2; k++) begin
                if (w_wr_load[k]) begin
                    r_load[k] <= wdata[CNT_W-1:0];
                end
                r_count[k] <= w_count_nxt[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_timer_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_timer_unit
// Purpose  : Self-checking bench for irq_timer_unit. Two instances share all
//            inputs: one with PRESCALE=1 (main checks) and one with
//            PRESCALE=4 (prescaler checks). Expected interrupt pulses are
//            queued when stimulus is driven and consumed by a per-cycle
//            monitor; register reads are compared inline in each test task.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_timer_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  io_irq;
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rdata4;
    logic [3:0]  interrupts;
    logic [3:0]  interrupts4;

    always #5 clk = ~clk;

    irq_timer_unit #(.CNT_W(32), .PRESCALE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .io_irq     (io_irq),
        .we         (we),
        .re         (re),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .interrupts (interrupts)
    );

    irq_timer_unit #(.CNT_W(32), .PRESCALE(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .io_irq     (io_irq),
        .we         (we),
        .re         (re),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata4),
        .interrupts (interrupts4)
    );

    // Edge counter: at a negedge, cyc is the index of the last rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } exp_t;

    exp_t       exp_q[$];
    bit         mon_on = 1'b0;
    logic [3:0] mon_exp;

    // Scoreboard consumer for the PRESCALE=1 instance's interrupt vector.
    always @(negedge clk) begin
        if (mon_on) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL irq_slot_skipped: expected %b at edge %0d never observed", exp_q[0].v, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            mon_exp = 4'b0000;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_exp = exp_q[0].v;
                void'(exp_q.pop_front());
            end
            checks++;
            if (interrupts !== mon_exp) begin
                errors++;
                $display("FAIL irq_vector at edge %0d: got %b, expected %b", cyc, interrupts, mon_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus primitives (tasks start and end just after a negedge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v, output logic [31:0] v4);
        re   = 1'b1;
        addr = a;
        step();
        re   = 1'b0;
        v    = rdata;
        v4   = rdata4;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] v, v4;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (rdata !== 32'h0 || rdata4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h, expected 0", rdata, rdata4);
        end
        checks++;
        if (interrupts !== 4'h0 || interrupts4 !== 4'h0) begin
            errors++;
            $display("FAIL reset_irq: got %b/%b, expected 0000", interrupts, interrupts4);
        end
        mon_on = 1'b1;
        io_irq = 2'b00;
        repeat (20) step();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v, v4);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr %0d: got %h, expected 0", a, v);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v, v4;
        int e;
        wr(3'd1, 32'd5);
        wr(3'd0, 32'h1);
        e = cyc;
        push_exp(e + 5, 4'b0100);
        rd(3'd3, v, v4);
        checks++;
        if (v !== 32'd5) begin
            errors++;
            $display("FAIL oneshot_count_start: got %0d, expected 5", v);
        end
        while (cyc < e + 7) step();
        rd(3'd3, v, v4);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL oneshot_count_end: got %0d, expected 0", v);
        end
        rd(3'd0, v, v4);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL oneshot_ctrl_cleared: got %h, expected 0", v);
        end
        rd(3'd5, v, v4);
        checks++;
        if (v !== 32'h4) begin
            errors++;
            $display("FAIL oneshot_status: got %h, expected 4", v);
        end
        wr(3'd5, 32'h4);
        rd(3'd5, v, v4);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL oneshot_status_w1c: got %h, expected 0", v);
        end
    endtask

    task automatic test_reload();
        logic [31:0] v, v4;
        int e;
        wr(3'd2, 32'd3);
        wr(3'd0, 32'hA);
        e = cyc;
        for (int i = 1; i <= 6; i++) push_exp(e + 3 * i, 4'b1000);
        for (int i = 0; i < 6; i++) begin
            rd(3'd4, v, v4);
            checks++;
            if (v !== 32'(3 - (i % 3))) begin
                errors++;
                $display("FAIL reload_count read %0d: got %0d, expected %0d", i, v, 3 - (i % 3));
            end
        end
        while (cyc < e + 20) step();
        // This write lands on what would have been the 7th expire edge.
        wr(3'd2, 32'd0);
        rd(3'd4, v, v4);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL reload_stop_count: got %0d, expected 0", v);
        end
        repeat (10) step();
        rd(3'd5, v, v4);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL reload_status: got %h, expected 8", v);
        end
        wr(3'd5, 32'hF);
        wr(3'd0, 32'h0);
    endtask

    task automatic test_io();
        logic [31:0] v, v4;
        wr(3'd0, 32'h30);
        io_irq = 2'b11;
        push_exp(cyc + 3, 4'b0011);
        repeat (10) step();
        io_irq = 2'b00;
        repeat (4) step();
        wr(3'd0, 32'h10);
        io_irq = 2'b11;
        push_exp(cyc + 3, 4'b0001);
        repeat (10) step();
        io_irq = 2'b00;
        repeat (4) step();
        rd(3'd5, v, v4);
        checks++;
        if (v !== 32'h3) begin
            errors++;
            $display("FAIL io_status: got %h, expected 3", v);
        end
        wr(3'd5, 32'hF);
        rd(3'd5, v, v4);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL io_status_w1c: got %h, expected 0", v);
        end
        wr(3'd0, 32'h0);
    endtask

    task automatic test_collision();
        logic [31:0] v, v4;
        int e;
        wr(3'd1, 32'd3);
        wr(3'd0, 32'h1);
        e = cyc;
        while (cyc < e + 2) step();
        // LOAD write on the expire edge: reload wins, no pulse.
        wr(3'd1, 32'd7);
        rd(3'd3, v, v4);
        checks++;
        if (v !== 32'd7) begin
            errors++;
            $display("FAIL collision_load_count: got %0d, expected 7", v);
        end
        push_exp(e + 10, 4'b0100);
        while (cyc < e + 9) step();
        // W1C on the expire edge: set wins.
        wr(3'd5, 32'h4);
        rd(3'd5, v, v4);
        checks++;
        if (v !== 32'h4) begin
            errors++;
            $display("FAIL collision_status_set_wins: got %h, expected 4", v);
        end
        rd(3'd0, v, v4);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL collision_ctrl: got %h, expected 0", v);
        end
        wr(3'd5, 32'hF);
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_prescaler();
        logic [31:0] v, v4;
        int e;
        int hits;
        mon_on = 1'b0;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        wr(3'd1, 32'd2);
        wr(3'd0, 32'h1);
        e    = cyc;
        hits = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (interrupts4[2]) begin
                hits++;
                checks++;
                if ((cyc - e) < 5 || (cyc - e) > 8) begin
                    errors++;
                    $display("FAIL prescale_pulse_time: got %0d cycles after enable, expected 5..8", cyc - e);
                end
            end
        end
        checks++;
        if (hits != 1) begin
            errors++;
            $display("FAIL prescale_pulse_count: got %0d, expected 1", hits);
        end
        // Reset in the middle of a count: nothing may fire afterwards.
        wr(3'd1, 32'd2);
        wr(3'd0, 32'h1);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (interrupts4 !== 4'h0) begin
                errors++;
                $display("FAIL prescale_reset_irq: got %b, expected 0000", interrupts4);
            end
        end
        rd(3'd3, v, v4);
        checks++;
        if (v4 !== 32'd0) begin
            errors++;
            $display("FAIL prescale_reset_count: got %0d, expected 0", v4);
        end
    endtask

    initial begin
        reset  = 1'b1;
        we     = 1'b0;
        re     = 1'b0;
        io_irq = 2'b00;
        addr   = 3'd0;
        wdata  = 32'h0;
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_reload();
        test_io();
        test_collision();
        test_prescaler();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_timer_unit.md
Name: irq_timer_unit

Overview:
- Interrupt source block directly upstream of the fetch stage.
- Drives the fetch stage's 4-bit interrupts input:
  - bit0 = IO interrupt 0
  - bit1 = IO interrupt 1
  - bit2 = counter0
  - bit3 = counter1
- Contains two synchronised, edge-detected external IO request lines and two programmable down-counters (one-shot or auto-reload).
- Software accesses it through a small word-addressed register port on the data-memory bus.

Parameters:
- CNT_W, 32, counter and load register width (1..32).
- PRESCALE, 1, core cycles per counter decrement tick (>=1).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- io_irq  input  2  asynchronous external request lines, rising-edge triggered
- we  input  1  register write strobe
- re  input  1  register read strobe
- addr  input  3  word address of register
- wdata  input  32  write data
- rdata  output  32  read data, registered
- interrupts  output  4  one-cycle interrupt pulses to fetch

Behaviour:
- Register map (word addresses):
  - 0 CTRL, R/W:
    - bit0 en0, bit1 en1
    - bit2 reload0, bit3 reload1
    - bit4 ioen0, bit5 ioen1
    - all other bits read 0
  - 1 LOAD0, R/W
  - 2 LOAD1, R/W
  - 3 COUNT0, RO
  - 4 COUNT1, RO
  - 5 STATUS, W1C: bits[3:0] are sticky copies of interrupts[3:0]
  - 6–7: reads return 0, writes ignored.
- Width handling:
  - LOAD/COUNT use the low CNT_W bits of wdata.
  - Reads zero-extend.
- Reset (clk edge with reset=1) clears:
  - CTRL, LOAD0/1, COUNT0/1, STATUS
  - synchroniser flops, edge flops, prescaler
  - rdata = 0, interrupts = 4'b0000
- Reset mid-count: the count is abandoned and no pulse is emitted.
- Read path: rdata is updated on the edge where re=1 and holds otherwise. It reflects register values before any same-edge write (1-cycle latency).
- Prescaler:
  - Free-running counter 0..PRESCALE-1.
  - tick=1 when it equals PRESCALE-1; the prescaler wraps to 0 on that tick.
  - With PRESCALE=1, tick is always 1.
- Counter channel k, per-channel FSM:
  - IDLE: enk=0, or COUNTk=0.
  - RUN: enk=1 and COUNTk>0. On tick: COUNTk <= COUNTk-1.
  - EXPIRE: the tick edge where COUNTk==1.
    - interrupts[2+k] <= 1 for exactly one cycle.
    - If reloadk=1: COUNTk <= LOADk and the FSM stays in RUN (period = LOADk ticks).
    - If reloadk=0: COUNTk <= 0 and hardware clears enk, returning to IDLE.
- Counter writes:
  - A write to LOADk sets LOADk and COUNTk to wdata on the same edge. This overrides a same-edge decrement or expire, and no pulse is emitted on that edge.
  - A CTRL write to enk does not alter COUNTk.
  - LOADk=0 with enk=1: remains IDLE and never interrupts.
  - Disabling (enk=0) freezes COUNTk.
  - Hardware clearing of enk on a one-shot expire and a same-edge CTRL write: the CTRL write wins.
- IO channel k:
  - io_irq[k] passes through a 2-flop synchroniser (s1, s2), then a history flop h.
  - rise = s2 & ~h.
  - interrupts[k] <= rise & ioenk, so the pulse is one cycle regardless of how long the input is held.
  - Latency: input high before edge E produces interrupts[k] high during the cycle after edge E+2.
  - Pulses while ioenk=0 are dropped, not deferred.
- interrupts outputs:
  - Registered; default low each cycle.
  - All four bits may pulse simultaneously.
- STATUS:
  - Bit j is set when interrupts[j] is set.
  - A write with wdata[j]=1 clears bit j.
  - Set and clear on the same edge: set wins.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then io_irq=0 for 20 cycles -> interrupts=0, rdata=0 on reads of all addresses, COUNT0=0.
- One-shot counter0: write LOAD0=5, then CTRL=0x1 -> interrupts[2] high for exactly 1 cycle, 5 cycles after the CTRL write edge. Afterwards COUNT0=0, CTRL read =0x0, STATUS=0x4. Write STATUS=0x4 -> STATUS=0.
- Auto-reload counter1: LOAD1=3, CTRL=0xA, run 20 cycles -> interrupts[3] pulses every 3 cycles (6 pulses). COUNT1 reads cycle through 3,2,1. Write LOAD1=0 -> pulses stop.
- IO edge: CTRL=0x30; hold io_irq=2'b11 for 10 cycles -> interrupts[1:0]=2'b11 for exactly 1 cycle, 3 edges after assertion. Same stimulus with CTRL=0x10 -> only bit0 pulses.
- Collisions (PRESCALE=1):
  - Write LOAD0=7 on the edge where COUNT0==1 -> no pulse and COUNT0=7.
  - STATUS W1C on the same edge as a counter0 expire -> STATUS[2] remains 1.
- Prescaler: PRESCALE=4, LOAD0=2, en0=1 -> interrupts[2] pulses 5–8 cycles after enable (2 ticks). Reset asserted mid-count -> no pulse, COUNT0=0.
